// File: rtl/ex_pipe_ctrl.sv
// Execute-stage hazard controller: operand forwarding, load-use stalls,
// multi-cycle MUL hold and taken-branch flush for a 5-stage MIPS pipeline.
module ex_pipe_ctrl #(
    parameter int MUL_LAT = 4
) (
    input  logic       clk_46,
    input  logic       rst_46,
    input  logic [5:0] id_opcode_46,
    input  logic [5:0] id_src_reg_46,
    input  logic [5:0] id_targ_reg_46,
    input  logic [5:0] ex_opcode_46,
    input  logic [5:0] ex_src_reg_46,
    input  logic [5:0] ex_targ_reg_46,
    input  logic [5:0] ex_dest_reg_46,
    input  logic [5:0] mem_opcode_46,
    input  logic [5:0] mem_dest_reg_46,
    input  logic [5:0] wb_opcode_46,
    input  logic [5:0] wb_dest_reg_46,
    input  logic       branch_taken_46,
    output logic [1:0] fwd_a_sel_46,
    output logic [1:0] fwd_b_sel_46,
    output logic       stall_46,
    output logic       ex_bubble_46,
    output logic       ex_hold_46,
    output logic       mem_bubble_46,
    output logic       flush_46,
    output logic       mul_done_46
);
    localparam logic [5:0] OP_ADD  = 6'b110001;
    localparam logic [5:0] OP_MUL  = 6'b100111;
    localparam logic [5:0] OP_ADDI = 6'b000100;
    localparam logic [5:0] OP_LDW  = 6'b010111;
    localparam logic [5:0] OP_STW  = 6'b010101;
    localparam logic [5:0] OP_BEQ  = 6'b100110;
    localparam logic [5:0] OP_BLT  = 6'b010110;

    localparam logic [3:0] LAST_CNT  = 4'(MUL_LAT - 1);
    localparam bit         MUL_MULTI = (MUL_LAT > 1);

    // Unlisted opcodes fall through every decode as NOPE.
    function automatic logic writes_dest(input logic [5:0] op);
        return (op == OP_ADD) || (op == OP_MUL) || (op == OP_ADDI) || (op == OP_LDW);
    endfunction

    function automatic logic reads_src(input logic [5:0] op);
        return (op == OP_ADD) || (op == OP_MUL) || (op == OP_ADDI) || (op == OP_LDW) ||
               (op == OP_STW) || (op == OP_BEQ) || (op == OP_BLT);
    endfunction

    function automatic logic reads_targ(input logic [5:0] op);
        return (op == OP_ADD) || (op == OP_MUL) || (op == OP_STW) ||
               (op == OP_BEQ) || (op == OP_BLT);
    endfunction

    // A loaded value is not ready in EX/MEM, so LDW only forwards from WB.
    function automatic logic [1:0] fwd_sel(input logic used, input logic [5:0] reg_id);
        logic [1:0] sel;
        sel = 2'b00;
        if (used && reg_id != 6'd0) begin
            if (writes_dest(mem_opcode_46) && mem_opcode_46 != OP_LDW &&
                mem_dest_reg_46 == reg_id)
                sel = 2'b01;
            else if (writes_dest(wb_opcode_46) && wb_dest_reg_46 == reg_id)
                sel = 2'b10;
        end
        return sel;
    endfunction

    typedef enum logic {RUN, MUL_BUSY} state_t;

    state_t     state;
    logic [3:0] cnt;
    logic       ex_is_mul;
    logic       lu;

    assign ex_is_mul = (ex_opcode_46 == OP_MUL);
    assign lu = (ex_opcode_46 == OP_LDW) && (ex_dest_reg_46 != 6'd0) &&
                ((reads_src(id_opcode_46)  && ex_dest_reg_46 == id_src_reg_46) ||
                 (reads_targ(id_opcode_46) && ex_dest_reg_46 == id_targ_reg_46));

    always_comb begin
        fwd_a_sel_46 = 2'b00;
        fwd_b_sel_46 = 2'b00;
        if (!rst_46) begin
            fwd_a_sel_46 = fwd_sel(reads_src(ex_opcode_46), ex_src_reg_46);
            fwd_b_sel_46 = fwd_sel(reads_targ(ex_opcode_46), ex_targ_reg_46);
        end
    end

    always_comb begin
        stall_46      = 1'b0;
        ex_bubble_46  = 1'b0;
        ex_hold_46    = 1'b0;
        mem_bubble_46 = 1'b0;
        flush_46      = 1'b0;
        mul_done_46   = 1'b0;
        if (!rst_46) begin
            case (state)
                RUN: begin
                    if (branch_taken_46) begin
                        flush_46      = 1'b1;
                        mem_bubble_46 = 1'b1;
                    end else if (ex_is_mul && MUL_MULTI) begin
                        stall_46      = 1'b1;
                        ex_hold_46    = 1'b1;
                        mem_bubble_46 = 1'b1;
                    end else if (lu) begin
                        stall_46     = 1'b1;
                        ex_bubble_46 = 1'b1;
                    end else if (ex_is_mul) begin
                        mul_done_46 = 1'b1;
                    end
                end
                MUL_BUSY: begin
                    if (cnt < LAST_CNT) begin
                        stall_46      = 1'b1;
                        ex_hold_46    = 1'b1;
                        mem_bubble_46 = 1'b1;
                    end else begin
                        mul_done_46 = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // cnt counts MUL EX cycles already spent; the first is spent in RUN.
    always_ff @(posedge clk_46) begin
        if (rst_46) begin
            state <= RUN;
            cnt   <= 4'd0;
        end else begin
            case (state)
                RUN: begin
                    if (!branch_taken_46 && ex_is_mul && MUL_MULTI) begin
                        state <= MUL_BUSY;
                        cnt   <= 4'd1;
                    end
                end
                MUL_BUSY: begin
                    if (cnt < LAST_CNT) begin
                        cnt <= cnt + 4'd1;
                    end else begin
                        state <= RUN;
                        cnt   <= 4'd0;
                    end
                end
                default: begin
                    state <= RUN;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ex_pipe_ctrl.sv
// Directed bench for ex_pipe_ctrl: each step drives one cycle of pipeline
// context, queues the expected control word and checks it mid-cycle.
module tb_ex_pipe_ctrl;
    localparam logic [5:0] ADD  = 6'b110001;
    localparam logic [5:0] MUL  = 6'b100111;
    localparam logic [5:0] ADDI = 6'b000100;
    localparam logic [5:0] LDW  = 6'b010111;
    localparam logic [5:0] STW  = 6'b010101;
    localparam logic [5:0] BR   = 6'b000110;
    localparam logic [5:0] NOPE = 6'b111111;
    localparam logic [5:0] UNK  = 6'b000000;

    // Control word: {fwd_a, fwd_b, stall, ex_bubble, ex_hold, mem_bubble, flush, mul_done}
    localparam logic [5:0] C_NONE = 6'b000000;
    localparam logic [5:0] C_LU   = 6'b110000;
    localparam logic [5:0] C_MUL  = 6'b101100;
    localparam logic [5:0] C_DONE = 6'b000001;
    localparam logic [5:0] C_BR   = 6'b000110;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] id_op, id_src, id_targ, ex_op, ex_src, ex_targ, ex_dest;
    logic [5:0] mem_op, mem_dest, wb_op, wb_dest;
    logic       br;
    logic [1:0] fwd_a, fwd_b;
    logic       stall, ex_bubble, ex_hold, mem_bubble, flush, mul_done;

    logic [9:0] exp_q[$];
    string      tag_q[$];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    ex_pipe_ctrl #(.MUL_LAT(4)) dut (
        .clk_46(clk), .rst_46(rst),
        .id_opcode_46(id_op), .id_src_reg_46(id_src), .id_targ_reg_46(id_targ),
        .ex_opcode_46(ex_op), .ex_src_reg_46(ex_src), .ex_targ_reg_46(ex_targ),
        .ex_dest_reg_46(ex_dest),
        .mem_opcode_46(mem_op), .mem_dest_reg_46(mem_dest),
        .wb_opcode_46(wb_op), .wb_dest_reg_46(wb_dest),
        .branch_taken_46(br),
        .fwd_a_sel_46(fwd_a), .fwd_b_sel_46(fwd_b),
        .stall_46(stall), .ex_bubble_46(ex_bubble), .ex_hold_46(ex_hold),
        .mem_bubble_46(mem_bubble), .flush_46(flush), .mul_done_46(mul_done)
    );

    task automatic clear_in();
        id_op = NOPE; id_src = 6'd0; id_targ = 6'd0;
        ex_op = NOPE; ex_src = 6'd0; ex_targ = 6'd0; ex_dest = 6'd0;
        mem_op = NOPE; mem_dest = 6'd0; wb_op = NOPE; wb_dest = 6'd0;
        br = 1'b0;
    endtask

    task automatic set_ex(input logic [5:0] op, input logic [5:0] s,
                          input logic [5:0] t, input logic [5:0] d);
        ex_op = op; ex_src = s; ex_targ = t; ex_dest = d;
    endtask

    task automatic set_id(input logic [5:0] op, input logic [5:0] s, input logic [5:0] t);
        id_op = op; id_src = s; id_targ = t;
    endtask

    task automatic set_mw(input logic [5:0] mop, input logic [5:0] md,
                          input logic [5:0] wop, input logic [5:0] wd);
        mem_op = mop; mem_dest = md; wb_op = wop; wb_dest = wd;
    endtask

    // Queue the expectation for the inputs just driven, then let the DUT
    // settle and compare at the falling edge before advancing one cycle.
    task automatic step(input string tag, input logic [1:0] ea,
                        input logic [1:0] eb, input logic [5:0] ectl);
        logic [9:0] obs;
        logic [9:0] expv;
        string      t;
        exp_q.push_back({ea, eb, ectl});
        tag_q.push_back(tag);
        @(negedge clk);
        expv = exp_q.pop_front();
        t    = tag_q.pop_front();
        obs  = {fwd_a, fwd_b, stall, ex_bubble, ex_hold, mem_bubble, flush, mul_done};
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", t, obs, expv);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_in();
        rst = 1'b1;
        // Forwarding and load-use conditions present but reset gates them.
        set_ex(ADD, 6'd3, 6'd4, 6'd7);
        set_mw(ADD, 6'd3, ADD, 6'd4);
        step("reset_gated", 2'b00, 2'b00, C_NONE);
        step("reset_hold", 2'b00, 2'b00, C_NONE);
        rst = 1'b0;

        step("fwd_mem_a_wb_b", 2'b01, 2'b10, C_NONE);
        set_mw(ADD, 6'd3, ADD, 6'd3);
        set_ex(ADD, 6'd3, 6'd3, 6'd7);
        step("fwd_mem_priority", 2'b01, 2'b01, C_NONE);
        set_mw(LDW, 6'd3, ADD, 6'd3);
        set_ex(ADD, 6'd3, 6'd0, 6'd7);
        step("fwd_ldw_mem_skip", 2'b10, 2'b00, C_NONE);
        set_ex(STW, 6'd7, 6'd8, 6'd0);
        set_mw(ADDI, 6'd8, LDW, 6'd7);
        step("fwd_stw_both", 2'b10, 2'b01, C_NONE);
        set_ex(ADDI, 6'd3, 6'd4, 6'd9);
        set_mw(ADD, 6'd3, ADD, 6'd4);
        step("fwd_addi_no_targ", 2'b01, 2'b00, C_NONE);
        set_ex(BR, 6'd3, 6'd4, 6'd0);
        step("fwd_br_no_reads", 2'b00, 2'b00, C_NONE);
        set_ex(ADD, 6'd3, 6'd4, 6'd9);
        set_mw(UNK, 6'd3, STW, 6'd4);
        step("fwd_nonwriters", 2'b00, 2'b00, C_NONE);

        clear_in();
        set_ex(LDW, 6'd1, 6'd0, 6'd5);
        set_id(ADD, 6'd5, 6'd6);
        step("lu_src", 2'b00, 2'b00, C_LU);
        clear_in();
        set_ex(ADD, 6'd5, 6'd6, 6'd9);
        set_mw(LDW, 6'd5, NOPE, 6'd0);
        step("lu_after_mem", 2'b00, 2'b00, C_NONE);
        set_mw(NOPE, 6'd0, LDW, 6'd5);
        step("lu_after_wb", 2'b10, 2'b00, C_NONE);
        clear_in();
        set_ex(LDW, 6'd1, 6'd0, 6'd9);
        set_id(STW, 6'd1, 6'd9);
        step("lu_targ", 2'b00, 2'b00, C_LU);
        set_id(BR, 6'd9, 6'd9);
        step("lu_br_no_reads", 2'b00, 2'b00, C_NONE);
        set_id(ADDI, 6'd2, 6'd9);
        step("lu_addi_no_targ", 2'b00, 2'b00, C_NONE);
        set_ex(LDW, 6'd0, 6'd0, 6'd0);
        set_id(ADD, 6'd0, 6'd0);
        set_mw(ADD, 6'd0, ADD, 6'd0);
        step("r0_no_hazard", 2'b00, 2'b00, C_NONE);

        clear_in();
        set_ex(MUL, 6'd2, 6'd3, 6'd4);
        br = 1'b1;
        step("br_over_mul", 2'b00, 2'b00, C_BR);
        set_ex(LDW, 6'd1, 6'd0, 6'd5);
        set_id(ADD, 6'd5, 6'd6);
        step("br_over_lu", 2'b00, 2'b00, C_BR);
        clear_in();
        set_ex(ADD, 6'd2, 6'd3, 6'd4);
        step("br_no_mul_busy", 2'b00, 2'b00, C_NONE);

        // MUL with a MEM producer of its src: forwarding runs during the hold.
        set_ex(MUL, 6'd2, 6'd3, 6'd4);
        set_mw(ADD, 6'd2, NOPE, 6'd0);
        for (int i = 1; i <= 3; i++) step($sformatf("mul_a_hold%0d", i), 2'b01, 2'b00, C_MUL);
        step("mul_a_done", 2'b01, 2'b00, C_DONE);
        clear_in();
        set_ex(MUL, 6'd2, 6'd3, 6'd4);
        step("mul_b_enter", 2'b00, 2'b00, C_MUL);
        br = 1'b1;
        step("mul_b_br_ignored", 2'b00, 2'b00, C_MUL);
        br = 1'b0;
        step("mul_b_hold3", 2'b00, 2'b00, C_MUL);
        step("mul_b_done", 2'b00, 2'b00, C_DONE);
        set_ex(ADD, 6'd2, 6'd3, 6'd4);
        step("mul_b_run", 2'b00, 2'b00, C_NONE);

        set_ex(MUL, 6'd2, 6'd3, 6'd4);
        step("mul_c_enter", 2'b00, 2'b00, C_MUL);
        rst = 1'b1;
        step("mul_c_reset", 2'b00, 2'b00, C_NONE);
        rst = 1'b0;
        clear_in();
        for (int i = 1; i <= 4; i++) step($sformatf("post_reset_run%0d", i), 2'b00, 2'b00, C_NONE);
        set_ex(MUL, 6'd2, 6'd3, 6'd4);
        for (int i = 1; i <= 3; i++) step($sformatf("mul_d_hold%0d", i), 2'b00, 2'b00, C_MUL);
        step("mul_d_done", 2'b00, 2'b00, C_DONE);
        clear_in();
        step("final_idle", 2'b00, 2'b00, C_NONE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ex_pipe_ctrl.md
Name: ex_pipe_ctrl

Overview:
- Hazard and sequencing controller for the execute stage of the 5-stage MIPS pipeline.
- Generates operand-forwarding selects for the EX operands.
- Detects load-use hazards and issues stalls/bubbles.
- Holds EX while a multi-cycle MUL completes.
- Flushes wrong-path instructions on a taken branch resolved in MEM.
- Sits beside the execute stage; drives the IF/ID, ID/EX and EX/MEM pipeline-register controls.

Parameters:
- MUL_LAT, 4, total EX cycles a MUL occupies (1..15); 1 means single-cycle, no hold.

Ports:
- clk_46  input  1  clock; all state updates on rising edge.
- rst_46  input  1  reset; synchronous, active-high.
- id_opcode_46  input  6  opcode in decode.
- id_src_reg_46  input  6  decode source register.
- id_targ_reg_46  input  6  decode target register.
- ex_opcode_46  input  6  opcode in execute.
- ex_src_reg_46  input  6  execute source register.
- ex_targ_reg_46  input  6  execute target register.
- ex_dest_reg_46  input  6  execute destination register.
- mem_opcode_46  input  6  opcode in memory stage.
- mem_dest_reg_46  input  6  memory-stage destination register.
- wb_opcode_46  input  6  opcode in writeback.
- wb_dest_reg_46  input  6  writeback destination register.
- branch_taken_46  input  1  branch in MEM resolved taken.
- fwd_a_sel_46  output  2  EX operand A source: 00 regfile, 01 EX/MEM ALU result, 10 MEM/WB result.
- fwd_b_sel_46  output  2  EX operand B source; same encoding as fwd_a_sel_46.
- stall_46  output  1  freeze PC and IF/ID.
- ex_bubble_46  output  1  ID/EX loads NOPE.
- ex_hold_46  output  1  ID/EX and EX operands hold.
- mem_bubble_46  output  1  EX/MEM loads NOPE.
- flush_46  output  1  IF/ID and ID/EX load NOPE.
- mul_done_46  output  1  one-cycle pulse on final MUL EX cycle.

Behaviour:
- Opcodes:
  - ADD=110001, MUL=100111, ADDI=000100, LDW=010111, STW=010101, BEQ=100110, BLT=010110, BR=000110, NOPE=111111.
  - Any other opcode is treated as NOPE.
- Register writers: ADD, MUL, ADDI, LDW (write dest).
- Reads src: ADD, MUL, ADDI, LDW, STW, BEQ, BLT.
- Reads targ: ADD, MUL, STW, BEQ, BLT.
- Register 0 is never a hazard or forwarding match.
- Reset:
  - While rst_46=1, all outputs are 0 (combinationally gated).
  - On the clock edge, state goes to RUN and cnt goes to 0.
  - Reset mid-MUL abandons the hold immediately.
- Forwarding (combinational, every cycle, independent of state), operand A uses ex_src_reg_46:
  - Select 01 if mem_opcode writes and is not LDW, and mem_dest==ex_src.
  - Else select 10 if wb_opcode writes and wb_dest==ex_src.
  - Else select 00.
  - The select is 00 if ex_opcode does not read src.
  - Operand B: same rules using ex_targ_reg_46.
  - MEM match has priority over WB match.
- Load-use hazard (lu):
  - Condition: ex_opcode==LDW, ex_dest!=0, and ex_dest equals id_src (if the id opcode reads src) or id_targ (if it reads targ).
- State machine, states RUN and MUL_BUSY; cnt is 4 bits. RUN, priority order:
  1. branch_taken_46: flush_46=1 and mem_bubble_46=1; no stall, no hold; stay RUN.
  2. ex_opcode==MUL and MUL_LAT>1: stall_46=1, ex_hold_46=1, mem_bubble_46=1; cnt<=1; next state MUL_BUSY.
  3. lu: stall_46=1, ex_bubble_46=1 for exactly one cycle; stay RUN.
  4. Otherwise all control outputs are 0.
  - With MUL_LAT=1, a MUL in EX raises mul_done_46 in RUN.
- MUL_BUSY:
  - If cnt<MUL_LAT-1: stall_46=1, ex_hold_46=1, mem_bubble_46=1; cnt<=cnt+1.
  - If cnt==MUL_LAT-1: outputs drop to 0 except mul_done_46=1; lu is not evaluated this cycle; next state RUN.
  - branch_taken_46 is ignored in MUL_BUSY (MEM holds bubbles, so it cannot be asserted legally).
- Resulting timing:
  - A MUL occupies EX for exactly MUL_LAT cycles.
  - Back-to-back MULs each take MUL_LAT cycles.
  - A load-use dependency costs 1 cycle.
  - After a load-use bubble, the dependent instruction reaches EX with the LDW in WB, so its select is 10.

Test Plan:
- ADD r3 in MEM, ADD in EX with src=r3, targ=r4, wb_dest=r4 -> fwd_a=01, fwd_b=10, no stall.
- LDW r5 in EX, id ADD src=r5 -> stall_46=1 and ex_bubble_46=1 for 1 cycle. Next cycle, with LDW in MEM and ADD in EX: fwd_a_sel=00 for that cycle (LDW excluded from MEM forwarding). Following cycle, with LDW in WB: fwd_a=10.
- MUL in EX, MUL_LAT=4 -> stall/ex_hold/mem_bubble high for 3 cycles; mul_done_46 on cycle 4; back in RUN on cycle 5.
- branch_taken_46=1 with MUL and lu present -> only flush_46 and mem_bubble_46 high; no MUL_BUSY entry.
- rst_46 asserted on the 2nd MUL_BUSY cycle -> outputs 0 that cycle; RUN with cnt=0 after the edge; no mul_done_46.
- Hazard with register 0: LDW r0 in EX, id src=r0 -> no stall; mem_dest=0 matching ex_src=0 -> fwd_a=00.
